// File: rtl/dcache_ctrl.sv
// Blocking L1 data-cache controller: sequences D_SRAM lookups, dirty write-back and block fill.
// Optional hit/miss/write-back counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int INDEX_W     = 5,
  parameter int BLOCK_BYTES = 32,
  localparam int OFF_W  = $clog2(BLOCK_BYTES),
  localparam int TAG_W  = ADDR_W - INDEX_W - OFF_W,
  localparam int BLK_W  = 8 * BLOCK_BYTES,
  localparam int BA_W   = TAG_W + INDEX_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req,
  input  logic                   cpu_wen,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [31:0]            cpu_wdata,
  input  logic [3:0]             cpu_be,
  output logic                   cpu_ready,
  output logic                   cpu_done,
  output logic [31:0]            cpu_rdata,
  output logic                   sram_en,
  output logic                   sram_wen,
  output logic                   sram_memWen,
  output logic [BLOCK_BYTES-1:0] sram_bytesAccess,
  output logic [BA_W-1:0]        sram_blockAddr,
  output logic [BLK_W-1:0]       sram_dataIn,
  input  logic                   sram_hit,
  input  logic                   sram_dirty,
  input  logic [TAG_W-1:0]       sram_victimTag,
  input  logic [BLK_W-1:0]       sram_dataOut,
  output logic                   mem_req,
  output logic                   mem_wen,
  output logic [BA_W-1:0]        mem_addr,
  output logic [BLK_W-1:0]       mem_wdata,
  input  logic                   mem_ready,
  input  logic [BLK_W-1:0]       mem_rdata,
  output logic [31:0]            stat_hits,
  output logic [31:0]            stat_misses,
  output logic [31:0]            stat_wbs
);

  localparam int WSEL_W = OFF_W - 2;
  localparam int WS_W   = (WSEL_W > 0) ? WSEL_W : 1;
  localparam int NWORDS = BLOCK_BYTES / 4;

  typedef enum logic [2:0] {IDLE, LOOKUP, WRHIT, WB, FILL, REISSUE} state_t;

  state_t state, nextState;

  logic [BA_W-1:0]  reqBlock;
  logic [WS_W-1:0]  reqWsel;
  logic             reqWen;
  logic [31:0]      reqWdata;
  logic [3:0]       reqBe;
  logic [TAG_W-1:0] victimTag;
  logic [BLK_W-1:0] victimData;

  logic [BA_W-1:0]  cpuBlock;
  logic [WS_W-1:0]  cpuWsel;
  logic             unusedAddrLsb;

  assign cpuBlock      = cpu_addr[ADDR_W-1:OFF_W];
  assign unusedAddrLsb = ^cpu_addr[1:0];

  generate
    if (WSEL_W > 0) begin : gWsel
      assign cpuWsel = cpu_addr[OFF_W-1:2];
    end else begin : gNoWsel
      assign cpuWsel = '0;
    end
  endgenerate

  function automatic logic [31:0] selectWord(input logic [BLK_W-1:0] blk, input logic [WS_W-1:0] ws);
    return blk[{ws, 5'b00000} +: 32];
  endfunction

  function automatic logic [BLOCK_BYTES-1:0] byteMask(input logic [3:0] be, input logic [WS_W-1:0] ws);
    logic [BLOCK_BYTES-1:0] m;
    m      = '0;
    m[3:0] = be;
    return m << {ws, 2'b00};
  endfunction

  // State register and request/victim capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      reqBlock   <= '0;
      reqWsel    <= '0;
      reqWen     <= 1'b0;
      reqWdata   <= '0;
      reqBe      <= '0;
      victimTag  <= '0;
      victimData <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && cpu_req) begin
        reqBlock <= cpuBlock;
        reqWsel  <= cpuWsel;
        reqWen   <= cpu_wen;
        reqWdata <= cpu_wdata;
        reqBe    <= cpu_be;
      end
      if (state == LOOKUP && !sram_hit && sram_dirty) begin
        victimTag  <= sram_victimTag;
        victimData <= sram_dataOut;
      end
    end
  end

  // Next state and all outputs
  always_comb begin
    nextState        = state;
    cpu_ready        = 1'b0;
    cpu_done         = 1'b0;
    cpu_rdata        = '0;
    sram_en          = 1'b0;
    sram_wen         = 1'b0;
    sram_memWen      = 1'b0;
    sram_bytesAccess = '0;
    sram_blockAddr   = '0;
    sram_dataIn      = '0;
    mem_req          = 1'b0;
    mem_wen          = 1'b0;
    mem_addr         = '0;
    mem_wdata        = '0;
    case (state)
      IDLE: begin
        cpu_ready = 1'b1;
        if (cpu_req) begin
          sram_en        = 1'b1;
          sram_blockAddr = cpuBlock;
          nextState      = LOOKUP;
        end
      end
      LOOKUP: begin
        if (sram_hit) begin
          if (reqWen) begin
            nextState = WRHIT;
          end else begin
            cpu_done  = 1'b1;
            cpu_rdata = selectWord(sram_dataOut, reqWsel);
            nextState = IDLE;
          end
        end else if (sram_dirty) begin
          nextState = WB;
        end else begin
          nextState = FILL;
        end
      end
      WRHIT: begin
        sram_en          = 1'b1;
        sram_wen         = 1'b1;
        sram_bytesAccess = byteMask(reqBe, reqWsel);
        sram_blockAddr   = reqBlock;
        sram_dataIn      = {NWORDS{reqWdata}};
        cpu_done         = 1'b1;
        nextState        = IDLE;
      end
      WB: begin
        mem_req   = 1'b1;
        mem_wen   = 1'b1;
        mem_addr  = {victimTag, reqBlock[INDEX_W-1:0]};
        mem_wdata = victimData;
        if (mem_ready) nextState = FILL;
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = reqBlock;
        if (mem_ready) begin
          // The fill lands in the array the same cycle the memory returns it
          sram_en          = 1'b1;
          sram_wen         = 1'b1;
          sram_memWen      = 1'b1;
          sram_bytesAccess = '1;
          sram_blockAddr   = reqBlock;
          sram_dataIn      = mem_rdata;
          nextState        = REISSUE;
        end
      end
      REISSUE: begin
        sram_en        = 1'b1;
        sram_blockAddr = reqBlock;
        nextState      = LOOKUP;
      end
      default: nextState = IDLE;
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hitCnt, missCnt, wbCnt;
  logic        reissued;

  // The lookup after a reissue is a guaranteed hit and must not skew the counts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hitCnt   <= '0;
      missCnt  <= '0;
      wbCnt    <= '0;
      reissued <= 1'b0;
    end else begin
      if (state == IDLE && cpu_req) reissued <= 1'b0;
      if (state == REISSUE) reissued <= 1'b1;
      if (state == LOOKUP && !reissued) begin
        if (sram_hit) hitCnt <= hitCnt + 32'd1;
        else          missCnt <= missCnt + 32'd1;
      end
      if (state == WB && mem_ready) wbCnt <= wbCnt + 32'd1;
    end
  end

  assign stat_hits   = hitCnt;
  assign stat_misses = missCnt;
  assign stat_wbs    = wbCnt;
`else
  assign stat_hits   = '0;
  assign stat_misses = '0;
  assign stat_wbs    = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with behavioural D_SRAM and memory models and
// scoreboards for CPU completions and memory transactions.
module tb_dcache_ctrl;
  localparam int ADDR_W = 32, INDEX_W = 5, BLOCK_BYTES = 32;
  localparam int OFF_W = 5, TAG_W = 22, BLK_W = 256, BA_W = 27;

  logic clk, rst;
  logic cpu_req, cpu_wen, cpu_ready, cpu_done;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0] cpu_be;
  logic sram_en, sram_wen, sram_memWen, sram_hit, sram_dirty;
  logic [BLOCK_BYTES-1:0] sram_bytesAccess;
  logic [BA_W-1:0] sram_blockAddr, mem_addr;
  logic [BLK_W-1:0] sram_dataIn, sram_dataOut, mem_wdata, mem_rdata;
  logic [TAG_W-1:0] sram_victimTag;
  logic mem_req, mem_wen, mem_ready;
  logic [31:0] stat_hits, stat_misses, stat_wbs;

  dcache_ctrl #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .BLOCK_BYTES(BLOCK_BYTES)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_be(cpu_be), .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_memWen(sram_memWen),
    .sram_bytesAccess(sram_bytesAccess), .sram_blockAddr(sram_blockAddr),
    .sram_dataIn(sram_dataIn), .sram_hit(sram_hit), .sram_dirty(sram_dirty),
    .sram_victimTag(sram_victimTag), .sram_dataOut(sram_dataOut),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_wbs(stat_wbs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  task automatic chk(input string tag, input logic [BLK_W-1:0] obs, input logic [BLK_W-1:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {logic wen; logic [BA_W-1:0] addr; logic [BLK_W-1:0] wdata;} memTxn_t;
  typedef struct {logic wen; logic [31:0] rdata;} cpuExp_t;
  memTxn_t expMemQ[$];
  cpuExp_t expCpuQ[$];
  logic    memWenLog[$];
  int      memLatency;

  logic [BLK_W-1:0] memStore [int unsigned];

  function automatic logic [BLK_W-1:0] patBlock(input int unsigned blk);
    logic [BLK_W-1:0] b;
    for (int i = 0; i < 8; i++)
      b[32*i +: 32] = (blk * 32'h9E37_79B9) ^ (32'h0101_0101 * i) ^ 32'h5A5A_0000;
    return b;
  endfunction

  function automatic logic [BLK_W-1:0] memBlock(input int unsigned blk);
    if (memStore.exists(blk)) return memStore[blk];
    return patBlock(blk);
  endfunction

  // Memory responder: answers after memLatency waiting cycles, checks stability and order
  initial begin
    int waitCnt;
    logic [BA_W-1:0] heldAddr;
    logic [BLK_W-1:0] heldData;
    memTxn_t e;
    waitCnt = 0;
    heldAddr = '0;
    heldData = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (rst && mem_req) begin
        if (waitCnt == 0) begin
          heldAddr = mem_addr;
          heldData = mem_wdata;
        end else begin
          chk("memAddrStable", mem_addr, heldAddr);
          chk("memWdataStable", mem_wdata, heldData);
        end
        if (waitCnt >= memLatency) begin
          mem_ready = 1'b1;
          memWenLog.push_back(mem_wen);
          chk("memTxnExpected", expMemQ.size() != 0, 1);
          if (expMemQ.size() != 0) begin
            e = expMemQ.pop_front();
            chk("memWen", mem_wen, e.wen);
            chk("memAddr", mem_addr, e.addr);
            if (e.wen) chk("memWdata", mem_wdata, e.wdata);
          end
          if (mem_wen) begin
            memStore[mem_addr] = mem_wdata;
            mem_rdata = '0;
          end else begin
            mem_rdata = memBlock(mem_addr);
          end
          waitCnt = 0;
        end else begin
          waitCnt++;
        end
      end else begin
        waitCnt = 0;
      end
    end
  end

  // D_SRAM model: registered lookup outputs, byte-masked writes, dirty tracking
  logic [TAG_W-1:0] sTag [32];
  logic             sValid [32];
  logic             sDirty [32];
  logic [BLK_W-1:0] sData [32];
  int               sramWrCount;
  logic [BLOCK_BYTES-1:0] lastBytes;
  logic             lastMemWen;
  logic [BLK_W-1:0] lastDataIn;

  initial begin
    logic [4:0] idx;
    logic [TAG_W-1:0] tg;
    logic [BLK_W-1:0] blk;
    for (int i = 0; i < 32; i++) begin
      sTag[i] = '0; sValid[i] = 1'b0; sDirty[i] = 1'b0; sData[i] = '0;
    end
    sramWrCount = 0;
    lastBytes = '0;
    lastMemWen = 1'b0;
    lastDataIn = '0;
    sram_hit = 1'b0; sram_dirty = 1'b0; sram_victimTag = '0; sram_dataOut = '0;
    forever begin
      @(posedge clk);
      idx = sram_blockAddr[4:0];
      tg  = sram_blockAddr[BA_W-1:5];
      if (sram_en && sram_wen) begin
        blk = sData[idx];
        for (int b = 0; b < BLOCK_BYTES; b++)
          if (sram_bytesAccess[b]) blk[8*b +: 8] = sram_dataIn[8*b +: 8];
        sData[idx] = blk;
        if (sram_memWen) begin
          sTag[idx] = tg; sValid[idx] = 1'b1; sDirty[idx] = 1'b0;
        end else begin
          sDirty[idx] = 1'b1;
        end
        sramWrCount++;
        lastBytes  = sram_bytesAccess;
        lastMemWen = sram_memWen;
        lastDataIn = sram_dataIn;
      end else if (sram_en) begin
        sram_hit       <= sValid[idx] && (sTag[idx] == tg);
        sram_dirty     <= sValid[idx] && sDirty[idx];
        sram_victimTag <= sTag[idx];
        sram_dataOut   <= sData[idx];
      end
    end
  end

  task automatic doReq(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] expRd, input int expLat);
    cpuExp_t e, c;
    int lat;
    e.wen = wen;
    e.rdata = expRd;
    expCpuQ.push_back(e);
    @(negedge clk);
    cpu_req = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
    chk("acceptReady", cpu_ready, 1);
    @(negedge clk);
    // Scramble the request inputs to prove the controller works from its own copy
    cpu_req = 1'b0; cpu_wen = ~wen; cpu_addr = ~addr; cpu_wdata = ~wdata; cpu_be = ~be;
    lat = 1;
    while (!cpu_done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("doneSeen", cpu_done, 1);
    if (cpu_done) begin
      c = expCpuQ.pop_front();
      if (!c.wen) chk("rdata", cpu_rdata, c.rdata);
      if (expLat > 0) chk("latency", lat, expLat);
    end
    @(negedge clk);
    chk("donePulse", cpu_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BLK_W-1:0] blk0, blk0wb, blkF, blk1;
    int wrBefore, logBefore;
    rst = 1'b0;
    cpu_req = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    memLatency = 50;
    blk0 = patBlock(0);
    blk0[128 +: 32] = 32'hDEAD_BEEF;
    memStore[0] = blk0;

    #23 rst = 1'b1;
    @(negedge clk);
    chk("rstReady", cpu_ready, 1);
    chk("rstDone", cpu_done, 0);
    chk("rstMemReq", mem_req, 0);
    chk("rstSramEn", sram_en, 0);

    // Start a clean miss and pull reset while it waits in FILL
    cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h0000_0040;
    @(negedge clk);
    cpu_req = 1'b0;
    for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
    chk("fillStarted", mem_req, 1);
    wrBefore = sramWrCount;
    #2 rst = 1'b0;
    #1 chk("rstDropsMemReq", mem_req, 0);
    chk("rstMidReady", cpu_ready, 1);
    @(negedge clk);
    @(negedge clk);
    chk("rstNoSramWrite", sramWrCount, wrBefore);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("postRstReady", cpu_ready, 1);
    chk("postRstMemReq", mem_req, 0);
    expCpuQ.delete();
    expMemQ.delete();

    memLatency = 3;
    expMemQ.push_back('{1'b0, 27'd0, '0});
    doReq(1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 7);
    chk("coldFillDrained", expMemQ.size(), 0);

    logBefore = memWenLog.size();
    doReq(1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1);
    chk("reloadNoMem", memWenLog.size(), logBefore);

    doReq(1'b1, 32'h0000_0013, 32'hAA00_0000, 4'b1000, 32'h0, 2);
    chk("storeBytes", lastBytes, 32'h0008_0000);
    chk("storeMemWen", lastMemWen, 0);
    chk("storeDataIn", lastDataIn, {8{32'hAA00_0000}});

    blk0wb = blk0;
    blk0wb[152 +: 8] = 8'hAA;
    blkF = patBlock(32'hFFC0_0010 >> 5);
    logBefore = memWenLog.size();
    expMemQ.push_back('{1'b1, 27'd0, blk0wb});
    expMemQ.push_back('{1'b0, 27'(32'hFFC0_0010 >> 5), '0});
    doReq(1'b0, 32'hFFC0_0010, 32'h0, 4'h0, blkF[128 +: 32], 11);
    chk("wbCount", memWenLog.size(), logBefore + 2);
    if (memWenLog.size() == logBefore + 2) begin
      chk("wbFirstWen", memWenLog[logBefore], 1);
      chk("fillSecondWen", memWenLog[logBefore + 1], 0);
    end

`ifdef DCACHE_STATS_EN
    chk("statHits", stat_hits, 2);
    chk("statMisses", stat_misses, 2);
    chk("statWbs", stat_wbs, 1);
`else
    chk("statHits", stat_hits, 0);
    chk("statMisses", stat_misses, 0);
    chk("statWbs", stat_wbs, 0);
`endif

    // Zero-wait clean miss brings back the written-back block
    memLatency = 0;
    expMemQ.push_back('{1'b0, 27'd0, '0});
    doReq(1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'hAAAD_BEEF, 4);

    doReq(1'b0, 32'h0000_001C, 32'h0, 4'h0, blk0[224 +: 32], 1);
    doReq(1'b1, 32'h0000_001C, 32'h5555_5555, 4'b0000, 32'h0, 2);
    chk("zeroBeBytes", lastBytes, 32'h0);
    chk("zeroBeMemWen", lastMemWen, 0);
    doReq(1'b0, 32'h0000_001C, 32'h0, 4'h0, blk0[224 +: 32], 1);

    blk1 = patBlock(1);
    expMemQ.push_back('{1'b0, 27'd1, '0});
    doReq(1'b1, 32'h0000_0024, 32'h1234_5678, 4'b0011, 32'h0, 5);
    chk("storeMissBytes", lastBytes, 32'h0000_0030);
    doReq(1'b0, 32'h0000_0024, 32'h0, 4'h0, {blk1[63:48], 16'h5678}, 1);

    chk("memQueueDrained", expMemQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
